bp_me_io_load_arbiter: RTL and testbench
========================================

// Module: bp_me_io_load_arbiter
// PURPOSE
//  2:1 arbiter merging the CCE-config loader (src 0) and NBF loader (src 1) I/O command streams onto one
//  host I/O link, replacing the fixed cfg_done mux. Sits directly upstream of the cce_to_io link.
//  Tracks outstanding requests in order and routes each I/O response back to the source that issued it.
// PARAMETERS
//  io_msg_width_p     none  width of packed bp_cce_io_msg_s
//  max_outstanding_p  4     depth of in-flight source-ID tracker (>=1)
//  src0_priority_p    0     1: fixed priority to src0; 0: round-robin
// PORTS
//  clk_i           in   1               clock
//  reset_i         in   1               async active-high reset
//  src_cmd_i       in   2*io_msg_width  [0]=cfg, [1]=nbf command
//  src_cmd_v_i     in   2               per-source command valid
//  src_cmd_yumi_o  out  2               per-source accept (one-hot or zero)
//  src_resp_o      out  2*io_msg_width  per-source response (same data on both halves)
//  src_resp_v_o    out  2               per-source response valid
//  src_resp_ready_i in  2               per-source response ready
//  io_cmd_o        out  io_msg_width    merged command
//  io_cmd_v_o      out  1               merged command valid
//  io_cmd_ready_i  in   1               link ready (ready-and)
//  io_resp_i       in   io_msg_width    link response
//  io_resp_v_i     in   1               link response valid
//  io_resp_yumi_o  out  1               response consumed
//  error_o         out  1               sticky: response received with nothing outstanding
// BEHAVIOUR
//  - Reset (async): rr pointer->src0, lock clear, tracker empty, error_o=0; all v/yumi outputs 0.
//  - Grant: eligible = src_cmd_v_i & ~tracker_full. RR picks src != last granted when both valid;
//    src0_priority_p=1 always picks src0 if valid. Zero-latency: io_cmd_o = granted src_cmd_i.
//  - Lock: once io_cmd_v_o is high with ready low, the grant holds until accepted (valid-stable rule).
//  - Accept: io_cmd_v_o & io_cmd_ready_i -> src_cmd_yumi_o[g]=1, push g into tracker, rr pointer<=g.
//  - Tracker full (count==max_outstanding_p): io_cmd_v_o=0. A pop in the same cycle does NOT free a
//    slot for a push that cycle (push gated on registered count only).
//  - Response: head ID h; src_resp_v_o[h]=io_resp_v_i, other=0; io_resp_yumi_o=io_resp_v_i &
//    src_resp_ready_i[h]; pop on yumi. In-order only; responses never reorder.
//  - Empty tracker + io_resp_v_i: yumi asserted (drop), error_o<=1 and stays until reset.
//  - Push and pop same cycle when not full: count unchanged, head/tail both advance.
//  - Reset mid-transaction: outstanding IDs discarded; late responses then set error_o.
// CONFIGURATION
//  BP_IO_ARB_STATS_EN defined: 32-bit saturating counters grant_cnt_r[2] and stall_full_cnt_r
//   (cycles with a valid source blocked by full tracker), exposed hierarchically; $display summary on
//   final. Undefined: counters absent, no extra logic; port list identical either way.
// STRUCTURE
//  - bp_me_pkg: typedef logic bp_io_arb_src_e {e_arb_src_cfg=0, e_arb_src_nbf=1}; localparam
//    io_arb_num_src_lp=2.
//  - Sub-module bp_me_io_src_tracker: circular FIFO of src IDs, depth max_outstanding_p,
//    head/tail ptrs with wrap, count register; outputs full/empty/head.
//  - Top: arbiter + lock FF + rr FF + response steer + error FF.
// TESTING
//  1 src0 only, 3 cmds, ready=1 -> 3 yumis on consecutive cycles; 3 responses all to src0 in order.
//  2 both valid continuously, rr, ready=1 -> grants 0,1,0,1; responses returned to 0,1,0,1.
//  3 both valid, ready low 5 cycles -> io_cmd_o/grant stable all 5 cycles; accepted on cycle 6.
//  4 max_outstanding_p=4, no responses -> 4 accepts then io_cmd_v_o=0; one resp pops, push resumes
//    next cycle not same cycle.
//  5 io_resp_v_i with empty tracker -> io_resp_yumi_o=1, no src_resp_v_o, error_o=1 sticky.
//  6 head=src1, src_resp_ready_i[1]=0 for 3 cycles -> io_resp_yumi_o=0 for 3, src0 gets nothing.

Source files
------------

// File: rtl/bp_me_io_load_arbiter_pkg.sv
// bp_me_io_load_arbiter_pkg: shared source-ID type and source count for the I/O load arbiter.
package bp_me_pkg;
    typedef enum logic {e_arb_src_cfg = 1'b0, e_arb_src_nbf = 1'b1} bp_io_arb_src_e;
    localparam int io_arb_num_src_lp = 2;
endpackage

// File: rtl/bp_me_io_load_arbiter_if.sv
// bp_me_io_load_arbiter_if: source-side and link-side handshake bundle for the I/O load arbiter.
interface bp_me_io_load_arbiter_if #(parameter int io_msg_width_p = 32);
    import bp_me_pkg::*;
    logic [io_arb_num_src_lp*io_msg_width_p-1:0] src_cmd_i;
    logic [io_arb_num_src_lp-1:0]                src_cmd_v_i;
    logic [io_arb_num_src_lp-1:0]                src_cmd_yumi_o;
    logic [io_arb_num_src_lp*io_msg_width_p-1:0] src_resp_o;
    logic [io_arb_num_src_lp-1:0]                src_resp_v_o;
    logic [io_arb_num_src_lp-1:0]                src_resp_ready_i;
    logic [io_msg_width_p-1:0]                   io_cmd_o;
    logic                                        io_cmd_v_o;
    logic                                        io_cmd_ready_i;
    logic [io_msg_width_p-1:0]                   io_resp_i;
    logic                                        io_resp_v_i;
    logic                                        io_resp_yumi_o;
    logic                                        error_o;
    modport slave (
        input  src_cmd_i, src_cmd_v_i, src_resp_ready_i, io_cmd_ready_i, io_resp_i, io_resp_v_i,
        output src_cmd_yumi_o, src_resp_o, src_resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o, error_o
    );
    modport master (
        output src_cmd_i, src_cmd_v_i, src_resp_ready_i, io_cmd_ready_i, io_resp_i, io_resp_v_i,
        input  src_cmd_yumi_o, src_resp_o, src_resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_yumi_o, error_o
    );
endinterface

// File: rtl/bp_me_io_load_arbiter_src_tracker.sv
// bp_me_io_src_tracker: in-order circular FIFO of source IDs for commands awaiting a response.
module bp_me_io_src_tracker
    import bp_me_pkg::*;
#(
    parameter int depth_p = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            push_i,
    input  bp_io_arb_src_e  id_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output bp_io_arb_src_e  head_o
);
    localparam int ptr_w_lp = depth_p > 1 ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [depth_p-1:0]  ids_q;

    assign head_d  = pop_i ? (head_q == ptr_w_lp'(depth_p - 1) ? '0 : head_q + 1'b1) : head_q;
    assign tail_d  = push_i ? (tail_q == ptr_w_lp'(depth_p - 1) ? '0 : tail_q + 1'b1) : tail_q;
    assign cnt_d   = cnt_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
    assign full_o  = cnt_q == cnt_w_lp'(depth_p);
    assign empty_o = cnt_q == '0;
    assign head_o  = bp_io_arb_src_e'(ids_q[head_q]);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ids_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (push_i) ids_q[tail_q] <= id_i;
        end
    end
endmodule

// File: rtl/bp_me_io_load_arbiter.sv
// bp_me_io_load_arbiter: 2:1 cfg/NBF I/O command arbiter with in-order response steering.
// Define BP_IO_ARB_STATS_EN to add saturating grant and full-stall counters.
module bp_me_io_load_arbiter
    import bp_me_pkg::*;
#(
    parameter int io_msg_width_p    = 32,
    parameter int max_outstanding_p = 4,
    parameter bit src0_priority_p   = 1'b0
) (
    input logic clk_i,
    input logic reset_i,
    bp_me_io_load_arbiter_if.slave io
);
    logic           full, empty, cmd_v, accept, resp_hit, pop;
    logic           lock_q, err_q;
    logic [1:0]     elig;
    bp_io_arb_src_e g, head, rr_q, lock_src_q;

    // A stalled grant is pinned so the link sees a stable command until it is taken.
    assign elig     = io.src_cmd_v_i & {2{~full}};
    assign g        = lock_q ? lock_src_q
                    : (&elig) ? (src0_priority_p ? e_arb_src_cfg : bp_io_arb_src_e'(~rr_q))
                    : bp_io_arb_src_e'(~elig[0]);
    assign cmd_v    = elig[g];
    assign accept   = cmd_v & io.io_cmd_ready_i;
    assign resp_hit = io.io_resp_v_i & ~empty;
    assign pop      = io.io_resp_yumi_o & ~empty;

    assign io.io_cmd_v_o     = cmd_v;
    assign io.io_cmd_o       = g == e_arb_src_nbf ? io.src_cmd_i[io_msg_width_p +: io_msg_width_p]
                                                  : io.src_cmd_i[0 +: io_msg_width_p];
    assign io.src_cmd_yumi_o = {accept & (g == e_arb_src_nbf), accept & (g == e_arb_src_cfg)};
    assign io.src_resp_o     = {2{io.io_resp_i}};
    assign io.src_resp_v_o   = {resp_hit & (head == e_arb_src_nbf), resp_hit & (head == e_arb_src_cfg)};
    // With nothing outstanding the response is swallowed so the link cannot wedge.
    assign io.io_resp_yumi_o = io.io_resp_v_i & (empty | io.src_resp_ready_i[head]);
    assign io.error_o        = err_q;

    bp_me_io_src_tracker #(.depth_p(max_outstanding_p)) tracker (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .push_i (accept),
        .id_i   (g),
        .pop_i  (pop),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q       <= e_arb_src_cfg;
            lock_q     <= 1'b0;
            lock_src_q <= e_arb_src_cfg;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= accept ? g : rr_q;
            lock_q     <= cmd_v & ~io.io_cmd_ready_i;
            lock_src_q <= g;
            err_q      <= err_q | (io.io_resp_v_i & empty);
        end
    end

`ifdef BP_IO_ARB_STATS_EN
    logic [31:0] grant_cnt_r [2];
    logic [31:0] stall_full_cnt_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_cnt_r[0]   <= '0;
            grant_cnt_r[1]   <= '0;
            stall_full_cnt_r <= '0;
        end else begin
            if (accept && grant_cnt_r[g] != '1) grant_cnt_r[g] <= grant_cnt_r[g] + 1'b1;
            if ((|io.src_cmd_v_i) && full && stall_full_cnt_r != '1) stall_full_cnt_r <= stall_full_cnt_r + 1'b1;
        end
    end

    final $display("io_load_arbiter stats: cfg grants %0d, nbf grants %0d, full stalls %0d",
                   grant_cnt_r[0], grant_cnt_r[1], stall_full_cnt_r);
`else
`endif
endmodule

// File: tb/tb_bp_me_io_load_arbiter.sv
// tb_bp_me_io_load_arbiter: directed, table-driven and random checks against a queue-based model.
module tb_bp_me_io_load_arbiter;
    import bp_me_pkg::*;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_me_io_load_arbiter_if #(.io_msg_width_p(W)) bus();

    bp_me_io_load_arbiter #(.io_msg_width_p(W), .max_outstanding_p(D), .src0_priority_p(1'b0)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .io     (bus)
    );

    int tests = 0;
    int fails = 0;
    // Reference model: outstanding source IDs in issue order, last granted source, pending stalled grant.
    int q[$];
    int last_g, held, held_src, err;
    logic [1:0]   s_yumi, s_rv;
    logic         s_cmd_v, s_ryumi, s_err;
    logic [W-1:0] s_cmd;

    typedef struct {
        logic [1:0] v;
        logic       rdy;
        logic       rv;
        logic [1:0] exp_yumi;
        logic [1:0] exp_rv;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy, input logic rv, input logic [1:0] rr);
        bus.src_cmd_v_i      = v;
        bus.io_cmd_ready_i   = rdy;
        bus.io_resp_v_i      = rv;
        bus.src_resp_ready_i = rr;
    endtask

    task automatic do_reset();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        rst = 1'b1;
        q.delete();
        last_g = 0; held = 0; held_src = 0; err = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: compare all outputs with the model at negedge, then advance the model at posedge.
    task automatic cyc();
        int g, v, h, full, ey;
        logic [1:0] el;
        @(negedge clk);
        full = q.size() == D;
        el   = full ? 2'b00 : bus.src_cmd_v_i;
        if (held != 0)       g = held_src;
        else if (el == 2'b11) g = 1 - last_g;
        else                 g = el[1] ? 1 : 0;
        v = el[g];
        h = q.size() > 0 ? q[0] : 0;
        ey = bus.io_resp_v_i && (q.size() == 0 || bus.src_resp_ready_i[h]);
        s_yumi = bus.src_cmd_yumi_o; s_cmd_v = bus.io_cmd_v_o; s_cmd = bus.io_cmd_o;
        s_rv = bus.src_resp_v_o; s_ryumi = bus.io_resp_yumi_o; s_err = bus.error_o;
        chk("cmd_v", s_cmd_v, v);
        chk("cmd_yumi", s_yumi, (v && bus.io_cmd_ready_i) ? (2'b01 << g) : 2'b00);
        if (v != 0) chk("cmd_data", s_cmd, bus.src_cmd_i[g*W +: W]);
        chk("resp_v", s_rv, (bus.io_resp_v_i && q.size() > 0) ? (2'b01 << h) : 2'b00);
        chk("resp_yumi", s_ryumi, ey);
        chk("resp_data", bus.src_resp_o, {2{bus.io_resp_i}});
        chk("error", s_err, err);
        @(posedge clk);
        if (bus.io_resp_v_i) begin
            if (q.size() == 0) err = 1;
            else if (bus.src_resp_ready_i[h]) void'(q.pop_front());
        end
        if (v != 0 && bus.io_cmd_ready_i) begin
            q.push_back(g);
            last_g = g;
        end
        held = v != 0 && !bus.io_cmd_ready_i;
        held_src = g;
        #1;
    endtask

    initial begin
        tbl[0] = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00};
        tbl[1] = '{2'b11, 1'b1, 1'b0, 2'b10, 2'b00};
        tbl[2] = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00};
        tbl[3] = '{2'b11, 1'b1, 1'b0, 2'b10, 2'b00};
        tbl[4] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b01};
        tbl[5] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b10};
        tbl[6] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b01};
        tbl[7] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b10};
        bus.src_cmd_i = 16'hB2A1;
        bus.io_resp_i = 8'h5C;
        do_reset();

        // Reset state
        cyc();
        chk("rst_cmd_v", s_cmd_v, 1'b0);
        chk("rst_yumi", s_yumi, 2'b00);
        chk("rst_err", s_err, 1'b0);

        // src0 alone: three back-to-back accepts, then three in-order responses to src0
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b1, 1'b0, 2'b11);
            cyc();
            chk("t1_yumi", s_yumi, 2'b01);
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1'b1, 1'b1, 2'b11);
            cyc();
            chk("t1_resp", s_rv, 2'b01);
        end
        // A single src1 command so src1 is the last grant and round-robin next favours src0
        drive(2'b10, 1'b1, 1'b0, 2'b11); cyc();
        chk("src1_yumi", s_yumi, 2'b10);
        drive(2'b00, 1'b1, 1'b1, 2'b11); cyc();
        chk("src1_resp", s_rv, 2'b10);

        // Round-robin grants 0,1,0,1 then responses 0,1,0,1
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].rdy, tbl[i].rv, 2'b11);
            cyc();
            chk($sformatf("rr_yumi%0d", i), s_yumi, tbl[i].exp_yumi);
            chk($sformatf("rr_resp%0d", i), s_rv, tbl[i].exp_rv);
        end

        // Link stalled 5 cycles: src0 command held steady, accepted on the sixth
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 1'b0, 1'b0, 2'b11);
            cyc();
            chk("stall_cmd", s_cmd, 8'hA1);
            chk("stall_yumi", s_yumi, 2'b00);
        end
        drive(2'b11, 1'b1, 1'b0, 2'b11); cyc();
        chk("stall_accept", s_yumi, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 2'b11); cyc();

        // Fill the tracker; a pop does not admit a push in the same cycle
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 1'b1, 1'b0, 2'b11);
            cyc();
            chk("fill_yumi", s_yumi, 2'b01);
        end
        cyc();
        chk("full_cmd_v", s_cmd_v, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'b11); cyc();
        chk("full_pop_cmd_v", s_cmd_v, 1'b0);
        chk("full_pop_yumi", s_ryumi, 1'b1);
        drive(2'b01, 1'b1, 1'b0, 2'b11); cyc();
        chk("resume_yumi", s_yumi, 2'b01);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b1, 1'b1, 2'b11);
            cyc();
        end

        // Head is src1 and src1 not ready: link response held, src0 sees nothing
        drive(2'b10, 1'b1, 1'b0, 2'b11); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1'b1, 1'b1, 2'b01);
            cyc();
            chk("bp_yumi", s_ryumi, 1'b0);
            chk("bp_resp", s_rv, 2'b10);
        end
        drive(2'b00, 1'b1, 1'b1, 2'b11); cyc();
        chk("bp_release", s_ryumi, 1'b1);

        // Response with nothing outstanding: dropped, error sticky
        drive(2'b00, 1'b1, 1'b1, 2'b11); cyc();
        chk("drop_yumi", s_ryumi, 1'b1);
        chk("drop_resp", s_rv, 2'b00);
        drive(2'b00, 1'b1, 1'b0, 2'b11);
        repeat (2) begin
            cyc();
            chk("err_sticky", s_err, 1'b1);
        end

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.src_cmd_i = 16'($urandom);
            bus.io_resp_i = 8'($urandom);
            drive(2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom));
            cyc();
        end

        // Reset with commands in flight: a late response is then unexpected
        do_reset();
        drive(2'b01, 1'b1, 1'b0, 2'b11);
        repeat (2) cyc();
        do_reset();
        drive(2'b00, 1'b1, 1'b1, 2'b11); cyc();
        chk("late_yumi", s_ryumi, 1'b1);
        drive(2'b00, 1'b1, 1'b0, 2'b11); cyc();
        chk("late_err", s_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
